// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the execute-stage multiply/divide unit.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } muldiv_state_e;

   function automatic logic op_is_div(input muldiv_op_e o);
      return o[2];
   endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Detects divide-by-zero and signed-overflow requests, whose results are
// fixed by the ISA and need no iteration.
module muldiv_special_case
   import riscv_pkg::*;
(
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            is_special,
   output logic [XLEN-1:0] special_result
);

   muldiv_op_e op_e;
   logic       div_zero;
   logic       overflow;

   assign op_e = muldiv_op_e'(op);

   always_comb begin
      div_zero       = op_is_div(op_e) && (B == '0);
      overflow       = ((op_e == OP_DIV) || (op_e == OP_REM)) &&
                       (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
      is_special     = div_zero || overflow;
      special_result = '0;
      if (div_zero)
         special_result = ((op_e == OP_DIV) || (op_e == OP_DIVU)) ? '1 : A;
      else if (overflow)
         special_result = (op_e == OP_DIV) ? A : '0;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up on the last step.
module muldiv_unit #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   import riscv_pkg::*;

   localparam int CW = $clog2(XLEN);

   muldiv_state_e     state;
   logic [CW-1:0]     counter;
   muldiv_op_e        op_in;
   muldiv_op_e        op_p0;
   logic              sign_a_p0, sign_b_p0;
   logic [2*XLEN-1:0] acc_p0;
   logic [XLEN-1:0]   opnd_b_p0;
   logic [2*XLEN-1:0] acc_nxt;
   logic              signed_a, signed_b, sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              is_special;
   logic [XLEN-1:0]   special_result;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     rem_sh;
   logic              rem_ge;

   assign op_in     = muldiv_op_e'(op);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   muldiv_special_case u_special (
      .op             (op),
      .A              (A),
      .B              (B),
      .is_special     (is_special),
      .special_result (special_result)
   );

   // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
   always_comb begin
      signed_a = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      signed_b = op_in inside {OP_MULH, OP_DIV, OP_REM};
      sign_a   = signed_a && A[XLEN-1];
      sign_b   = signed_b && B[XLEN-1];
      mag_a    = sign_a ? ('0 - A) : A;
      mag_b    = sign_b ? ('0 - B) : B;
   end

   // acc holds {high product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      sum    = {1'b0, acc_p0[2*XLEN-1:XLEN]} + (acc_p0[0] ? {1'b0, opnd_b_p0} : '0);
      rem_sh = {acc_p0[2*XLEN-1:XLEN], acc_p0[XLEN-1]};
      rem_ge = (rem_sh >= {1'b0, opnd_b_p0});
      if (!op_is_div(op_p0))
         acc_nxt = {sum, acc_p0[XLEN-1:1]};
      else if (rem_ge)
         acc_nxt = {rem_sh[XLEN-1:0] - opnd_b_p0, acc_p0[XLEN-2:0], 1'b1};
      else
         acc_nxt = {rem_sh[XLEN-1:0], acc_p0[XLEN-2:0], 1'b0};
   end

   function automatic logic [XLEN-1:0] fixup(input muldiv_op_e o,
                                             input logic [2*XLEN-1:0] r,
                                             input logic sa, input logic sb);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quo;
      logic [XLEN-1:0]   rem;
      logic [XLEN-1:0]   res;
      prod = (sa ^ sb) ? ('0 - r) : r;
      quo  = (sa ^ sb) ? ('0 - r[XLEN-1:0]) : r[XLEN-1:0];
      rem  = sa ? ('0 - r[2*XLEN-1:XLEN]) : r[2*XLEN-1:XLEN];
      case (o)
         OP_MUL:                     res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:            res = quo;
         default:                    res = rem;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= '0;
         result  <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               counter <= '0;
               if (is_special) begin
                  result <= special_result;
                  state  <= DONE;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               counter <= counter + CW'(1);
               if (counter == CW'(XLEN-1)) begin
                  result <= fixup(op_p0, acc_nxt, sign_a_p0, sign_b_p0);
                  state  <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Operand capture at acceptance, then one iteration per CALC cycle.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         op_p0     <= op_in;
         sign_a_p0 <= sign_a;
         sign_b_p0 <= sign_b;
         acc_p0    <= {{XLEN{1'b0}}, mag_a};
         opnd_b_p0 <= mag_b;
      end else if (state == CALC) begin
         acc_p0 <= acc_nxt;
      end
   end

endmodule
